// File: rtl/axil_mem_tester.sv
// AXI4-Lite write-then-readback tester: writes NUM_WORDS address-derived words, reads them
// back, and reports pass/fail, a saturating error count and the first failing address.
module axil_mem_tester #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       NUM_WORDS   = 1024,
  parameter logic [31:0]       PATTERN_XOR = 32'hA5A5_5A5A,
  parameter int unsigned       TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [2:0]        m_awprot,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [2:0]        dbg_state
);

  localparam int unsigned IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_FIN
  } state_t;

  state_t            state, next_state;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     tmo_cnt;
  logic              aw_done, w_done;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       exp_data;
  logic              last_word, waiting, hs, aw_hs, w_hs, beat, beat_err, abort;

  assign cur_addr  = BASE_ADDR + (ADDR_W'(idx) << 2);
  assign exp_data  = 32'(cur_addr) ^ PATTERN_XOR;
  assign last_word = (idx == IW'(NUM_WORDS - 1));
  assign waiting   = (state == S_WR_REQ) || (state == S_WR_RESP) ||
                     (state == S_RD_REQ) || (state == S_RD_RESP);

  assign m_awaddr  = cur_addr;
  assign m_araddr  = cur_addr;
  assign m_wdata   = exp_data;
  assign m_wstrb   = 4'hF;
  assign m_awprot  = 3'b000;
  assign m_arprot  = 3'b000;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= next_state;
  end

  // Valid/ready: a transfer occurs on each rising edge where valid and ready are both high;
  // once raised, a valid and its payload stay unchanged until that edge.
  always_comb begin
    next_state = state;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    hs         = 1'b0;
    beat       = 1'b0;
    beat_err   = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: if (start) next_state = S_WR_REQ;
      S_WR_REQ: begin
        m_awvalid = ~aw_done;
        m_wvalid  = ~w_done;
        aw_hs     = m_awvalid & m_awready;
        w_hs      = m_wvalid & m_wready;
        hs        = aw_hs | w_hs;
        if ((aw_done | aw_hs) && (w_done | w_hs)) next_state = S_WR_RESP;
      end
      S_WR_RESP: begin
        m_bready = 1'b1;
        hs       = m_bvalid;
        beat     = m_bvalid;
        beat_err = (m_bresp != 2'b00);
        if (m_bvalid) next_state = last_word ? S_RD_REQ : S_WR_REQ;
      end
      S_RD_REQ: begin
        m_arvalid = 1'b1;
        hs        = m_arready;
        if (m_arready) next_state = S_RD_RESP;
      end
      S_RD_RESP: begin
        m_rready = 1'b1;
        hs       = m_rvalid;
        beat     = m_rvalid;
        beat_err = (m_rresp != 2'b00) || (m_rdata != exp_data);
        if (m_rvalid) next_state = last_word ? S_FIN : S_RD_REQ;
      end
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    // The handshake cycle itself never counts toward the abort limit.
    if (waiting && !hs && (tmo_cnt == TW'(TIMEOUT_CYC - 1))) begin
      abort      = 1'b1;
      next_state = S_FIN;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      idx            <= '0;
      tmo_cnt        <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      if ((next_state != state) || hs) tmo_cnt <= '0;
      else if (waiting)                tmo_cnt <= tmo_cnt + TW'(1);

      if (next_state != S_WR_REQ) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end

      if ((state == S_IDLE) && start) begin
        idx            <= '0;
        busy           <= 1'b1;
        done           <= 1'b0;
        pass           <= 1'b0;
        timeout        <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
      end

      if (beat) begin
        idx <= last_word ? '0 : idx + IW'(1);
        if (beat_err) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          if (err_count == 16'd0)    first_err_addr <= cur_addr;
        end
      end

      if (abort) timeout <= 1'b1;

      if (state == S_FIN) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == 16'd0) && !timeout;
      end
    end
  end

endmodule

// File: tb/tb_axil_mem_tester.sv
// Directed bench for axil_mem_tester: a small AXI-Lite RAM slave with fault/stall knobs,
// logs of every handshake, and immediate-assertion checks after each scenario.
module tb_axil_mem_tester;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              sys_rst, start;
  logic              busy, done, pass, timeout;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [ADDR_W-1:0] m_awaddr, m_araddr;
  logic [2:0]        m_awprot, m_arprot, dbg_state;
  logic              m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
  logic              m_bvalid = 1'b0, m_rvalid = 1'b0;
  logic [1:0]        m_bresp = 2'b00, m_rresp = 2'b00;
  logic [31:0]       m_rdata = 32'h0;

  always #5 clk = ~clk;

  axil_mem_tester #(
    .ADDR_W(ADDR_W), .BASE_ADDR(32'h0), .NUM_WORDS(4),
    .PATTERN_XOR(32'hA5A5_5A5A), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .start(start),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .dbg_state(dbg_state)
  );

  // Slave knobs, written only by the stimulus process.
  int unsigned aw_min = 0, aw_max = 0, w_min = 0, w_max = 0;
  bit          never_ar = 1'b0, corrupt_all = 1'b0, corrupt_one = 1'b0, bresp_err = 1'b0;
  logic [31:0] corrupt_addr = 32'h0, bresp_err_addr = 32'h0;

  // Slave state and handshake logs, written only by the slave process.
  logic [31:0] mem [16];
  logic [31:0] aw_log[$], w_log[$], ar_log[$];
  int          ar_cycles = 0;
  int unsigned aw_wait = 0, w_wait = 0;
  bit          aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0, b_fire = 1'b0, r_fire = 1'b0;
  logic [31:0] aw_a, w_d, ar_a, rd_word;

  // Slave acts on falling edges; a ready raised here against a high valid completes on the next rising edge.
  initial begin : slave
    forever begin
      @(negedge clk);
      if (sys_rst) begin
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_bvalid = 1'b0;  m_rvalid = 1'b0;
        aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; b_fire = 1'b0; r_fire = 1'b0;
      end else begin
        if (b_fire) m_bvalid = 1'b0;
        if (r_fire) m_rvalid = 1'b0;
        if (aw_got && w_got && !m_bvalid) begin
          mem[aw_a[5:2]] = w_d;
          m_bresp  = (bresp_err && aw_a == bresp_err_addr) ? 2'b10 : 2'b00;
          m_bvalid = 1'b1;
          aw_got = 1'b0; w_got = 1'b0;
        end
        if (ar_got) begin
          rd_word = mem[ar_a[5:2]];
          if (corrupt_all) rd_word = ~rd_word;
          if (corrupt_one && ar_a == corrupt_addr) rd_word[0] = ~rd_word[0];
          m_rdata = rd_word; m_rresp = 2'b00; m_rvalid = 1'b1;
          ar_got = 1'b0;
        end
        m_awready = 1'b0;
        if (m_awvalid && !aw_got) begin
          if (aw_wait == 0) begin
            m_awready = 1'b1; aw_got = 1'b1; aw_a = m_awaddr; aw_log.push_back(m_awaddr);
          end else aw_wait--;
        end else aw_wait = $urandom_range(aw_max, aw_min);
        m_wready = 1'b0;
        if (m_wvalid && !w_got) begin
          if (w_wait == 0) begin
            m_wready = 1'b1; w_got = 1'b1; w_d = m_wdata; w_log.push_back(m_wdata);
          end else w_wait--;
        end else w_wait = $urandom_range(w_max, w_min);
        m_arready = 1'b0;
        if (m_arvalid) begin
          ar_cycles++;
          if (!never_ar && !ar_got && !m_rvalid) begin
            m_arready = 1'b1; ar_got = 1'b1; ar_a = m_araddr; ar_log.push_back(m_araddr);
          end
        end
        b_fire = m_bvalid && m_bready;
        r_fire = m_rvalid && m_rready;
      end
    end
  end

  int          n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr [4];
  logic [31:0] exp_data [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_test(input string tag);
    pulse_start();
    check({tag, "_busy_on_start"}, 64'(busy), 64'd1);
    check({tag, "_done_cleared"}, 64'(done), 64'd0);
    check({tag, "_err_cleared"}, 64'(err_count), 64'd0);
    for (int i = 0; i < 400 && !done; i++) tick();
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  task automatic check_results(input string tag, input logic p, input logic t,
                               input logic [15:0] e, input logic [31:0] fa);
    check({tag, "_pass"}, 64'(pass), 64'(p));
    check({tag, "_timeout"}, 64'(timeout), 64'(t));
    check({tag, "_err_count"}, 64'(err_count), 64'(e));
    check({tag, "_first_err_addr"}, 64'(first_err_addr), 64'(fa));
  endtask

  task automatic check_traffic(input string tag, input int aw0, input int w0, input int ar0,
                               input int n_rd);
    logic [31:0] e;
    check({tag, "_aw_count"}, 64'(aw_log.size() - aw0), 64'd4);
    check({tag, "_w_count"}, 64'(w_log.size() - w0), 64'd4);
    check({tag, "_ar_count"}, 64'(ar_log.size() - ar0), 64'(n_rd));
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_data[i]);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      if (w0 + i < w_log.size())
        check($sformatf("%s_wdata%0d", tag, i), 64'(w_log[w0+i]), 64'(e));
      if (aw0 + i < aw_log.size())
        check($sformatf("%s_awaddr%0d", tag, i), 64'(aw_log[aw0+i]), 64'(exp_addr[i]));
      if (i < n_rd && ar0 + i < ar_log.size())
        check($sformatf("%s_araddr%0d", tag, i), 64'(ar_log[ar0+i]), 64'(exp_addr[i]));
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int aw0, w0, ar0, arc0;
    exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_data = '{32'hA5A5_5A5A, 32'hA5A5_5A5E, 32'hA5A5_5A52, 32'hA5A5_5A56};
    sys_rst = 1'b1;
    start   = 1'b0;
    repeat (3) tick();

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_first_err_addr", 64'(first_err_addr), 64'd0);
    check("rst_awvalid", 64'(m_awvalid), 64'd0);
    check("rst_wvalid", 64'(m_wvalid), 64'd0);
    check("rst_bready", 64'(m_bready), 64'd0);
    check("rst_arvalid", 64'(m_arvalid), 64'd0);
    check("rst_rready", 64'(m_rready), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("wstrb", 64'(m_wstrb), 64'hF);
    check("prot", 64'({m_awprot, m_arprot}), 64'd0);
    sys_rst = 1'b0;
    repeat (2) tick();

    // Clean pass against a zero-wait slave.
    aw0 = aw_log.size(); w0 = w_log.size(); ar0 = ar_log.size();
    run_test("t1");
    check_results("t1", 1'b1, 1'b0, 16'd0, 32'h0);
    check_traffic("t1", aw0, w0, ar0, 4);

    // Single flipped bit on the read of 0x8.
    corrupt_one = 1'b1; corrupt_addr = 32'h8;
    run_test("t2");
    check_results("t2", 1'b0, 1'b0, 16'd1, 32'h8);
    corrupt_one = 1'b0;

    // Independent random stalls on AW and W.
    aw_max = 5; w_max = 5;
    aw0 = aw_log.size(); w0 = w_log.size(); ar0 = ar_log.size();
    run_test("t3");
    check_results("t3", 1'b1, 1'b0, 16'd0, 32'h0);
    check_traffic("t3", aw0, w0, ar0, 4);
    aw_max = 0; w_max = 0;

    // SLVERR on the second write plus every read word inverted.
    bresp_err = 1'b1; bresp_err_addr = 32'h4; corrupt_all = 1'b1;
    run_test("t4");
    check_results("t4", 1'b0, 1'b0, 16'd5, 32'h4);
    bresp_err = 1'b0; corrupt_all = 1'b0;

    // Read address never accepted: abort after 16 cycles, mid-test start ignored.
    never_ar = 1'b1;
    aw0 = aw_log.size(); w0 = w_log.size(); ar0 = ar_log.size(); arc0 = ar_cycles;
    pulse_start();
    check("t5_busy_on_start", 64'(busy), 64'd1);
    for (int i = 0; i < 100 && !m_arvalid; i++) tick();
    check("t5_arvalid_seen", 64'(m_arvalid), 64'd1);
    pulse_start();
    check("t5_busy_after_extra_start", 64'(busy), 64'd1);
    check("t5_arvalid_after_extra_start", 64'(m_arvalid), 64'd1);
    for (int i = 0; i < 100 && !done; i++) tick();
    check("t5_done", 64'(done), 64'd1);
    check_results("t5", 1'b0, 1'b1, 16'd0, 32'h0);
    check("t5_ar_wait_cycles", 64'(ar_cycles - arc0), 64'd16);
    check_traffic("t5", aw0, w0, ar0, 0);
    never_ar = 1'b0;

    // Reset while the write request is stalled, then a clean pass.
    aw_min = 3; aw_max = 3;
    pulse_start();
    for (int i = 0; i < 20 && !m_awvalid; i++) tick();
    check("t6_awvalid_seen", 64'(m_awvalid), 64'd1);
    sys_rst = 1'b1;
    tick();
    check("t6_rst_awvalid", 64'(m_awvalid), 64'd0);
    check("t6_rst_wvalid", 64'(m_wvalid), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_done", 64'(done), 64'd0);
    check("t6_rst_timeout", 64'(timeout), 64'd0);
    sys_rst = 1'b0;
    aw_min = 0; aw_max = 0;
    repeat (2) tick();
    aw0 = aw_log.size(); w0 = w_log.size(); ar0 = ar_log.size();
    run_test("t6");
    check_results("t6", 1'b1, 1'b0, 16'd0, 32'h0);
    check_traffic("t6", aw0, w0, ar0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
